gate_truth_table_sequencer: RTL and testbench

Self-test controller for the two-input basic-gate unit (AND, OR, NAND, NOR, XOR, XNOR outputs y1..y6). On a start request it drives the gate unit's `a`/`b` inputs through all four input combinations and waits a programmable settle time per vector. It captures the six gate outputs per vector into a 24-bit truth table, compares against the golden table and reports per-gate pass/fail. It sits beside the gate unit as its only driver of `a`/`b` and replaces hand-written stimulus with an on-chip check.

---
 rtl/gate_truth_table_sequencer_if.sv | 23 ++
 rtl/gate_truth_table_sequencer.sv | 132 +++++++++++++
 tb/tb_gate_truth_table_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/gate_truth_table_sequencer_if.sv
// Bundle between the truth-table sequencer and its environment: run control,
// gate-unit stimulus/response and the captured results.
interface gate_truth_table_sequencer_if;
  logic        start;
  logic [5:0]  y_in;
  logic        gate_a;
  logic        gate_b;
  logic        busy;
  logic        done;
  logic        pass;
  logic [5:0]  fail_mask;
  logic [23:0] table_out;

  modport master (
    output start, y_in,
    input  gate_a, gate_b, busy, done, pass, fail_mask, table_out
  );

  modport slave (
    input  start, y_in,
    output gate_a, gate_b, busy, done, pass, fail_mask, table_out
  );
endinterface

// File: rtl/gate_truth_table_sequencer.sv
// Self-test sequencer for the two-input gate unit: sweeps {a,b} through 00..11,
// captures the six gate outputs per vector and checks them against a golden table.
module gate_truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [23:0] EXPECTED      = 24'h8D65AC
) (
  input logic                          clk,
  input logic                          rst_n,
  gate_truth_table_sequencer_if.slave  bus
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned K_W   = 2;
  localparam int unsigned Y_W   = 6;
  localparam int unsigned TBL_W = 24;
  localparam int unsigned NVEC  = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(NVEC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_e;

  state_e             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TBL_W-1:0]   table_q, table_d;
  logic [Y_W-1:0]     fail_q, fail_d;
  logic               pass_q, pass_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               gate_a_q, gate_a_d;
  logic               gate_b_q, gate_b_d;
  logic               capture_c;
  logic [Y_W-1:0]     mismatch_c;

  assign capture_c = (state_q == SETTLE) && (cnt_q == CNT_LAST);

  // State register and all datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      cnt_q    <= '0;
      table_q  <= '0;
      fail_q   <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      gate_a_q <= 1'b0;
      gate_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      table_q  <= table_d;
      fail_q   <= fail_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SETTLE;
      SETTLE:  if (capture_c && (k_q == K_LAST)) state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-gate mismatch accumulated over all four captured vectors
  always_comb begin
    mismatch_c = '0;
    for (int unsigned i = 0; i < NVEC; i++) begin
      mismatch_c = mismatch_c | (table_q[i*Y_W +: Y_W] ^ EXPECTED[i*Y_W +: Y_W]);
    end
  end

  // Output and datapath next values
  always_comb begin
    k_d     = k_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    fail_d  = fail_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          k_d     = '0;
          cnt_d   = '0;
          table_d = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (capture_c) begin
          cnt_d = '0;
          for (int unsigned i = 0; i < NVEC; i++) begin
            if (k_q == K_W'(i)) table_d[i*Y_W +: Y_W] = bus.y_in;
          end
          if (k_q != K_LAST) k_d = k_q + K_W'(1);
        end
      end
      CHECK: begin
        fail_d = mismatch_c;
        pass_d = (mismatch_c == '0);
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
    // Stimulus follows the vector index while a run is active, parks at 00 otherwise
    {gate_a_d, gate_b_d} = (state_d == IDLE) ? 2'b00 : k_d;
  end

  assign bus.gate_a    = gate_a_q;
  assign bus.gate_b    = gate_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_q;
  assign bus.table_out = table_q;
endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Directed bench for gate_truth_table_sequencer with a behavioural gate unit
// (optional OR stuck-at-0) and a scoreboard of expected run results.
module tb_gate_truth_table_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stuck_or = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  typedef struct {
    logic [23:0] tbl;
    logic        pass;
    logic [5:0]  mask;
  } exp_t;

  exp_t sb[$];
  exp_t golden;
  exp_t faulty;

  always #5 clk = ~clk;

  gate_truth_table_sequencer_if bus();

  gate_truth_table_sequencer #(
    .SETTLE_CYCLES(2),
    .EXPECTED(24'h8D65AC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Behavioural gate unit: y6 XNOR, y5 XOR, y4 NOR, y3 NAND, y2 OR, y1 AND
  assign bus.y_in = {~(bus.gate_a ^ bus.gate_b), bus.gate_a ^ bus.gate_b,
                     ~(bus.gate_a | bus.gate_b), ~(bus.gate_a & bus.gate_b),
                     (bus.gate_a | bus.gate_b) & ~stuck_or, bus.gate_a & bus.gate_b};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run: optional pre-asserted start (back-to-back), optional ignored start pokes,
  // optional chaining of the next start into the done cycle.
  task automatic run(input string tag, input exp_t e, input bit pre_started,
                     input bit poke, input bit chain);
    int   e0;
    int   n;
    int   dc0;
    bit   seen;
    exp_t x;
    sb.push_back(e);
    if (!pre_started) bus.start = 1'b1;
    step();
    e0 = cyc;
    dc0 = done_cnt;
    bus.start = 1'b0;
    chk({tag, "_busy_acc"}, 32'(bus.busy), 32'd1);
    chk({tag, "_tbl_clr"}, 32'(bus.table_out), 32'd0);
    chk({tag, "_pass_clr"}, 32'(bus.pass), 32'd0);
    chk({tag, "_mask_clr"}, 32'(bus.fail_mask), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      n = cyc - e0;
      if (n < 8) chk({tag, "_vec"}, 32'({bus.gate_a, bus.gate_b}), 32'(n / 2));
      if (bus.done) begin
        seen = 1'b1;
        x = sb.pop_front();
        chk({tag, "_latency"}, 32'(n), 32'd9);
        chk({tag, "_table"}, 32'(bus.table_out), 32'(x.tbl));
        chk({tag, "_pass"}, 32'(bus.pass), 32'(x.pass));
        chk({tag, "_mask"}, 32'(bus.fail_mask), 32'(x.mask));
        chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
        chk({tag, "_gates_done"}, 32'({bus.gate_a, bus.gate_b}), 32'd0);
      end else begin
        bus.start = (poke && (n == 2 || n == 7)) ? 1'b1 : 1'b0;
        step();
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'(bus.done), 32'd1);
    if (chain) begin
      bus.start = 1'b1;
    end else begin
      step();
      chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      repeat (3) step();
      chk({tag, "_done_count"}, 32'(done_cnt - dc0), 32'd1);
      chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_hold_table"}, 32'(bus.table_out), 32'(e.tbl));
    end
  endtask

  initial begin
    int dc;
    golden = '{tbl: 24'h8D65AC, pass: 1'b1, mask: 6'b000000};
    faulty = '{tbl: 24'h85452C, pass: 1'b0, mask: 6'b000010};
    bus.start = 1'b0;

    // Reset held with start toggling
    for (int i = 0; i < 4; i++) begin
      bus.start = ~bus.start;
      step();
    end
    chk("rst_gate_a", 32'(bus.gate_a), 32'd0);
    chk("rst_gate_b", 32'(bus.gate_b), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_pass", 32'(bus.pass), 32'd0);
    chk("rst_mask", 32'(bus.fail_mask), 32'd0);
    chk("rst_table", 32'(bus.table_out), 32'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    repeat (2) step();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    run("golden", golden, 1'b0, 1'b0, 1'b0);

    stuck_or = 1'b1;
    run("fault_or", faulty, 1'b0, 1'b0, 1'b0);
    stuck_or = 1'b0;

    run("busy_prot", golden, 1'b0, 1'b1, 1'b0);

    // Mid-run reset at E0+5
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    chk("abort_pre_tbl", 32'(bus.table_out), 32'h0005AC);
    chk("abort_pre_busy", 32'(bus.busy), 32'd1);
    dc = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_gate_a", 32'(bus.gate_a), 32'd0);
    chk("abort_gate_b", 32'(bus.gate_b), 32'd0);
    chk("abort_table", 32'(bus.table_out), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
    run("after_abort", golden, 1'b0, 1'b0, 1'b0);

    // Back-to-back: start held in the done cycle of the first run
    stuck_or = 1'b1;
    run("b2b_first", faulty, 1'b0, 1'b0, 1'b1);
    stuck_or = 1'b0;
    run("b2b_second", golden, 1'b1, 1'b0, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
